vga_timing_gen: RTL and testbench

Generates 640x480@60 Hz VGA timing from the 50 MHz system clock and drives the VGA connector. It is the producing end of the DrawX/DrawY pixel-coordinate interface consumed by the colour mapper. It also samples the mapper's 24-bit colour back and registers it onto VGA_R/G/B with sync and blank aligned to the colour. One instance sits at top level between the colour mapper and the DAC pins.

---
 rtl/vga_timing_gen_if.sv | 22 ++
 rtl/vga_timing_gen.sv | 128 ++++++++++++
 tb/tb_vga_timing_gen.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Pixel-coordinate link between the VGA timing generator (master) and the colour mapper (slave).
// The mapper returns the colour for the current DrawX/DrawY on rgb_in.
interface vga_timing_gen_if;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        frame_start;
  logic [23:0] rgb_in;

  modport master (
    output DrawX,
    output DrawY,
    output frame_start,
    input  rgb_in
  );

  modport slave (
    input  DrawX,
    input  DrawY,
    input  frame_start,
    output rgb_in
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing from a 50 MHz clock, with the registered sync/blank/colour output stage.
// Build option VGA_TEST_PATTERN_EN adds a test_pattern input that replaces rgb_in with 8 colour bars.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  vga_timing_gen_if.master       pix,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                   test_pattern,
`endif
  output logic                   VGA_CLK,
  output logic                   VGA_HS,
  output logic                   VGA_VS,
  output logic                   VGA_BLANK_N,
  output logic                   VGA_SYNC_N,
  output logic [7:0]             VGA_R,
  output logic [7:0]             VGA_G,
  output logic [7:0]             VGA_B
);

  localparam logic [9:0] H_LAST     = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST     = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic        pix_en;
  logic [9:0]  hc;
  logic [9:0]  vc;
  logic        h_last;
  logic        v_last;
  logic        hs_d;
  logic        vs_d;
  logic        vis_d;
  logic [23:0] pix_rgb;
  logic        frame_start_q;

  assign h_last = (hc == H_LAST);
  assign v_last = (vc == V_LAST);

  assign pix.DrawX       = hc;
  assign pix.DrawY       = vc;
  assign pix.frame_start = frame_start_q;
  assign VGA_SYNC_N      = 1'b0;

  // Pixel enable every second Clk; VGA_CLK trails it by one Clk so it rises with each counter step.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_en  <= 1'b0;
      VGA_CLK <= 1'b0;
    end else begin
      pix_en  <= ~pix_en;
      VGA_CLK <= pix_en;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hc <= '0;
      vc <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        hc <= '0;
        vc <= v_last ? '0 : vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

  // Pulse marks the edge where the counters land on (0,0); the post-reset start does not count.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= pix_en && h_last && v_last;
    end
  end

  assign hs_d  = !((hc >= HS_START) && (hc < HS_END));
  assign vs_d  = !((vc >= VS_START) && (vc < VS_END));
  assign vis_d = (hc < H_VIS) && (vc < V_VIS);

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [9:0] BAR_W = 10'(H_VISIBLE / 8);

  logic [2:0]  bar;
  logic [23:0] bar_rgb;

  // Bar order white, yellow, cyan, green, magenta, red, blue, black falls out of the index bits.
  assign bar     = 3'(hc / BAR_W);
  assign bar_rgb = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
  assign pix_rgb = test_pattern ? bar_rgb : pix.rgb_in;
`else
  assign pix_rgb = pix.rgb_in;
`endif

  // Single output register stage keeps sync, blank and colour aligned one pixel behind the counters.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else if (pix_en) begin
      VGA_HS      <= hs_d;
      VGA_VS      <= vs_d;
      VGA_BLANK_N <= vis_d;
      VGA_R       <= vis_d ? pix_rgb[23:16] : 8'h00;
      VGA_G       <= vis_d ? pix_rgb[15:8]  : 8'h00;
      VGA_B       <= vis_d ? pix_rgb[7:0]   : 8'h00;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a reduced timing set so whole frames stay short.
// Expected values come from a pixel-count model: Clk edges since reset -> pixel index -> (x,y).
module tb_vga_timing_gen;
  localparam int HV = 32, HF = 4, HSW = 8, HB = 6;
  localparam int VV = 12, VF = 2, VSW = 2, VB = 3;
  localparam int HT = HV + HF + HSW + HB;
  localparam int VT = VV + VF + VSW + VB;
  localparam int FRAME = HT * VT;
  localparam int BAR = HV / 8;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
  logic [7:0] VGA_R, VGA_G, VGA_B;
`ifdef VGA_TEST_PATTERN_EN
  logic test_pattern = 1'b0;
`endif

  vga_timing_gen_if pix();

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .pix(pix),
`ifdef VGA_TEST_PATTERN_EN
    .test_pattern(test_pattern),
`endif
    .VGA_CLK(VGA_CLK),
    .VGA_HS(VGA_HS),
    .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_SYNC_N(VGA_SYNC_N),
    .VGA_R(VGA_R),
    .VGA_G(VGA_G),
    .VGA_B(VGA_B)
  );

  always #10 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int n = 0;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       clk;
    logic       fs;
    logic       hs;
    logic       vs;
    logic       bl;
  } exp_t;

  function automatic bit m_hs_n(int h);
    return !(h >= HV + HF && h < HV + HF + HSW);
  endfunction

  function automatic bit m_vs_n(int v);
    return !(v >= VV + VF && v < VV + VF + VSW);
  endfunction

  // Expected state after nn Clk edges since reset release; registered outputs show pixel p-1.
  function automatic exp_t model(int nn);
    exp_t e;
    int p, q, h, v;
    p = nn / 2;
    e.x   = 10'(p % HT);
    e.y   = 10'((p / HT) % VT);
    e.clk = (nn > 0) && (nn % 2 == 0);
    e.fs  = e.clk && (p % FRAME == 0);
    if (p == 0) begin
      e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b0;
    end else begin
      q = p - 1;
      h = q % HT;
      v = (q / HT) % VT;
      e.hs = m_hs_n(h);
      e.vs = m_vs_n(v);
      e.bl = (h < HV) && (v < VV);
    end
    return e;
  endfunction

  function automatic logic [23:0] bar_colour(int h);
    logic [23:0] tbl [8];
    tbl = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    return tbl[h / BAR];
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
    n++;
  endtask

  task automatic release_reset();
    Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    n = 0;
  endtask

  task automatic test_reset();
    pix.rgb_in = 24'hABCDEF;
    repeat (4) @(posedge Clk);
    #1;
    checks++;
    if ({pix.DrawX, pix.DrawY} !== 20'd0) begin
      errors++; $display("FAIL reset_xy got %0d,%0d expected 0,0", pix.DrawX, pix.DrawY);
    end
    checks++;
    if ({VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, pix.frame_start} !== 6'b011000) begin
      errors++;
      $display("FAIL reset_ctl got clk/hs/vs/bl/sync/fs=%b expected 011000",
               {VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, pix.frame_start});
    end
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h0) begin
      errors++; $display("FAIL reset_rgb got %h expected 000000", {VGA_R, VGA_G, VGA_B});
    end
  endtask

  // Two full frames with a fresh random colour before every pixel edge.
  task automatic test_frame();
    exp_t e;
    logic [23:0] rgb_now, e_rgb;
    int first_fs;
    first_fs = -1;
    rgb_now = 24'h0;
    release_reset();
    for (int i = 0; i < 4 * FRAME + 6; i++) begin
      tick();
      e = model(n);
      e_rgb = e.bl ? rgb_now : 24'h0;
      if (pix.frame_start === 1'b1 && first_fs < 0) first_fs = n;
      checks++;
      if ({pix.DrawX, pix.DrawY} !== {e.x, e.y}) begin
        errors++;
        $display("FAIL frame_xy n=%0d got %0d,%0d expected %0d,%0d", n, pix.DrawX, pix.DrawY, e.x, e.y);
      end
      checks++;
      if ({VGA_CLK, pix.frame_start, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N} !==
          {e.clk, e.fs, e.hs, e.vs, e.bl, 1'b0}) begin
        errors++;
        $display("FAIL frame_ctl n=%0d got clk/fs/hs/vs/bl/sync=%b expected %b", n,
                 {VGA_CLK, pix.frame_start, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N},
                 {e.clk, e.fs, e.hs, e.vs, e.bl, 1'b0});
      end
      checks++;
      if ({VGA_R, VGA_G, VGA_B} !== e_rgb) begin
        errors++; $display("FAIL frame_rgb n=%0d got %h expected %h", n, {VGA_R, VGA_G, VGA_B}, e_rgb);
      end
      if (n % 2 == 1) begin
        rgb_now = 24'($urandom);
        pix.rgb_in = rgb_now;
      end
    end
    checks++;
    if (first_fs != 2 * FRAME) begin
      errors++; $display("FAIL first_frame_start got edge %0d expected %0d", first_fs, 2 * FRAME);
    end
  endtask

  task automatic test_sync_widths();
    int hs_low, vs_low, hs_falls, vs_falls, hs_per_vs;
    bit prev_hs, prev_vs, found;
    hs_low = 0; vs_low = 0; hs_falls = 0; vs_falls = 0; hs_per_vs = -1;
    found = 0;
    for (int i = 0; i < 2 * FRAME + 4 && !found; i++) begin
      tick();
      if (pix.frame_start === 1'b1) found = 1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL sync_wait_frame got no frame_start expected one within %0d edges", 2 * FRAME + 4);
    end
    prev_hs = VGA_HS; prev_vs = VGA_VS;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (!VGA_HS) hs_low++;
      if (!VGA_VS) vs_low++;
      if (prev_hs && !VGA_HS) begin
        hs_falls++;
        checks++;
        if (pix.DrawX !== 10'(HV + HF + 1)) begin
          errors++; $display("FAIL hs_fall_pos got x=%0d expected %0d", pix.DrawX, HV + HF + 1);
        end
      end
      if (prev_vs && !VGA_VS) begin
        vs_falls++;
        checks++;
        if ({pix.DrawX, pix.DrawY} !== {10'd1, 10'(VV + VF)}) begin
          errors++;
          $display("FAIL vs_fall_pos got %0d,%0d expected 1,%0d", pix.DrawX, pix.DrawY, VV + VF);
        end
        if (vs_falls == 1) hs_falls = 0;
      end
      prev_hs = VGA_HS; prev_vs = VGA_VS;
    end
    // Finish out to the next VS fall so a whole VS period of HS pulses is counted.
    for (int i = 0; i < 2 * FRAME + 4 && hs_per_vs < 0; i++) begin
      tick();
      if (prev_hs && !VGA_HS) hs_falls++;
      if (prev_vs && !VGA_VS) hs_per_vs = hs_falls;
      prev_hs = VGA_HS; prev_vs = VGA_VS;
    end
    checks++;
    if (hs_low != 2 * HSW * VT) begin
      errors++; $display("FAIL hs_low_clk got %0d expected %0d", hs_low, 2 * HSW * VT);
    end
    checks++;
    if (vs_low != 2 * VSW * HT) begin
      errors++; $display("FAIL vs_low_clk got %0d expected %0d", vs_low, 2 * VSW * HT);
    end
    checks++;
    if (hs_per_vs != VT) begin
      errors++; $display("FAIL hs_per_vs got %0d expected %0d", hs_per_vs, VT);
    end
  endtask

  task automatic test_const_rgb();
    exp_t e;
    int lit;
    lit = 0;
    pix.rgb_in = 24'h123456;
    tick(); tick();
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      e = model(n);
      if ({VGA_R, VGA_G, VGA_B} === 24'h123456) lit++;
      checks++;
      if ({VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== {e.bl, (e.bl ? 24'h123456 : 24'h0)}) begin
        errors++;
        $display("FAIL const_rgb n=%0d got bl=%b rgb=%h expected bl=%b", n, VGA_BLANK_N,
                 {VGA_R, VGA_G, VGA_B}, e.bl);
      end
    end
    checks++;
    if (lit != 2 * HV * VV) begin
      errors++; $display("FAIL const_lit_count got %0d expected %0d", lit, 2 * HV * VV);
    end
  endtask

  task automatic test_midframe_reset();
    exp_t e;
    int th, tv;
    bit hit;
    th = $urandom_range(1, HT - 1);
    tv = $urandom_range(1, VT - 1);
    hit = 0;
    for (int i = 0; i < 2 * FRAME + 4 && !hit; i++) begin
      tick();
      if (pix.DrawX == 10'(th) && pix.DrawY == 10'(tv)) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL midreset_seek got no hit expected %0d,%0d", th, tv);
    end
    #3;
    Reset_n = 1'b0;
    #1;
    checks++;
    if ({pix.DrawX, pix.DrawY, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, pix.frame_start,
         VGA_R, VGA_G, VGA_B} !== {20'd0, 5'b01100, 24'h0}) begin
      errors++;
      $display("FAIL midreset_async got x=%0d y=%0d clk/hs/vs/bl/fs=%b rgb=%h expected 0 0 01100 000000",
               pix.DrawX, pix.DrawY, {VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, pix.frame_start},
               {VGA_R, VGA_G, VGA_B});
    end
    release_reset();
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      tick();
      e = model(n);
      checks++;
      if ({pix.DrawX, pix.DrawY, pix.frame_start} !== {e.x, e.y, e.fs}) begin
        errors++;
        $display("FAIL midreset_run n=%0d got %0d,%0d fs=%b expected %0d,%0d fs=%b", n,
                 pix.DrawX, pix.DrawY, pix.frame_start, e.x, e.y, e.fs);
      end
    end
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern_bars();
    exp_t e;
    logic [23:0] e_rgb, got;
    int q, h, v;
    test_pattern = 1'b1;
    tick(); tick();
    for (int i = 0; i < 2 * FRAME; i++) begin
      pix.rgb_in = 24'($urandom);
      tick();
      e = model(n);
      q = n / 2 - 1;
      h = q % HT;
      v = (q / HT) % VT;
      e_rgb = e.bl ? bar_colour(h) : 24'h0;
      got = {VGA_R, VGA_G, VGA_B};
      checks++;
      if (got !== e_rgb) begin
        errors++; $display("FAIL pattern n=%0d pixel %0d,%0d got %h expected %h", n, h, v, got, e_rgb);
      end
      if (n % 2 == 0 && v == 0 && (h == 0 || h == BAR || h == HV - 1)) begin
        checks++;
        if (got !== (h == 0 ? 24'hFFFFFF : (h == BAR ? 24'hFFFF00 : 24'h000000))) begin
          errors++; $display("FAIL pattern_pixel_%0d got %h", h, got);
        end
      end
    end
    test_pattern = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_sync_widths();
    test_const_rgb();
    test_midframe_reset();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern_bars();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
